// File: rtl/dtc_pkg.sv
// Shared opcodes, FSM state encoding and error-flag indices for the SPI/BRAM
// transfer controller.
package dtc_pkg;

    localparam logic [7:0] OpWrite  = 8'h01;
    localparam logic [7:0] OpRead   = 8'h02;
    localparam logic [7:0] OpStatus = 8'h03;

    // Encodings 6 and 7 are reserved and fall back to StIdle.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdr   = 3'd1,
        StCheck = 3'd2,
        StWrite = 3'd3,
        StRdPre = 3'd4,
        StRead  = 3'd5
    } state_e;

    localparam int unsigned ErrBadCmd   = 0;
    localparam int unsigned ErrBadSize  = 1;
    localparam int unsigned ErrBadRange = 2;
    localparam int unsigned ErrW        = 3;

    localparam int unsigned HdrBytes = 4;

endpackage

// File: rtl/dtc_hdr_collector.sv
// Collects the 4-byte command header (MSB first) into two DIM_W fields.
// hdr_done is asserted combinationally with the byte that completes the header.
module dtc_hdr_collector
    import dtc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIM_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DIM_W-1:0] field_a,
    output logic [DIM_W-1:0] field_b,
    output logic             hdr_done
);

    logic [2*DIM_W-1:0] shreg;
    logic [1:0]         cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[2*DIM_W-DATA_W-1:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end

    assign hdr_done = byte_valid && (cnt == 2'(HdrBytes - 1));
    assign field_a  = shreg[2*DIM_W-1:DIM_W];
    assign field_b  = shreg[DIM_W-1:0];

endmodule

// File: rtl/spi_bram_xfer_ctrl.sv
// Command decoder between the byte-level SPI slave and the image BRAM:
// image write, windowed read-back with one-cycle BRAM latency, and status query.
module spi_bram_xfer_ctrl
    import dtc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned MEM_DEPTH = 19200,
    parameter int unsigned DIM_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    output logic [DATA_W-1:0] tx_byte,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic [ErrW-1:0]   err
);

    localparam int unsigned CntW = $clog2(MEM_DEPTH + 1);
    localparam logic [2*DIM_W:0] DepthW = (2*DIM_W+1)'(MEM_DEPTH);

    state_e            cur_state;
    logic [CntW-1:0]   remaining;
    logic              rd_wait;
    logic              is_write;

    logic              hdr_valid;
    logic              hdr_done;
    logic [DIM_W-1:0]  field_a;
    logic [DIM_W-1:0]  field_b;

    logic [2*DIM_W-1:0] total;
    logic [2*DIM_W:0]   wide_total;
    logic [2*DIM_W:0]   sum_ab;
    logic               size_bad;
    logic               range_bad;
    logic [DATA_W-1:0]  status_byte;

    // Abort has priority, so a byte arriving as chip-select drops is not collected.
    assign hdr_valid = byte_valid && frame_active && (cur_state == StHdr);

    dtc_hdr_collector #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W)
    ) u_hdr (
        .clk        (clk),
        .rst        (rst),
        .clr        (cur_state == StIdle),
        .byte_valid (hdr_valid),
        .byte_in    (byte_in),
        .field_a    (field_a),
        .field_b    (field_b),
        .hdr_done   (hdr_done)
    );

    assign total      = {{DIM_W{1'b0}}, field_a} * {{DIM_W{1'b0}}, field_b};
    assign wide_total = {1'b0, total};
    assign sum_ab     = {{(DIM_W+1){1'b0}}, field_a} + {{(DIM_W+1){1'b0}}, field_b};
    assign size_bad   = (total == '0) || (wide_total > DepthW);
    assign range_bad  = (field_b == '0) || (sum_ab > DepthW);

    always_comb begin
        status_byte = '0;
        status_byte[ErrW-1:0] = err;
        status_byte[7] = busy;
    end

    assign state = cur_state;
    assign busy  = (cur_state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= StIdle;
            remaining  <= '0;
            rd_wait    <= 1'b0;
            is_write   <= 1'b0;
            tx_byte    <= '0;
            bram_addr  <= '0;
            bram_we    <= 1'b0;
            bram_wdata <= '0;
            done       <= 1'b0;
            err        <= '0;
        end else begin
            bram_we <= 1'b0;
            done    <= 1'b0;
            // Address advances in the cycle after each write pulse.
            if (bram_we) begin
                bram_addr <= bram_addr + ADDR_W'(1);
            end

            if (cur_state != StIdle && !frame_active) begin
                cur_state <= StIdle;
                rd_wait   <= 1'b0;
            end else begin
                case (cur_state)
                    StIdle: begin
                        if (byte_valid) begin
                            if (byte_in == DATA_W'(OpWrite)) begin
                                is_write  <= 1'b1;
                                cur_state <= StHdr;
                            end else if (byte_in == DATA_W'(OpRead)) begin
                                is_write  <= 1'b0;
                                cur_state <= StHdr;
                            end else if (byte_in == DATA_W'(OpStatus)) begin
                                tx_byte <= status_byte;
                                err     <= '0;
                            end else begin
                                err[ErrBadCmd] <= 1'b1;
                            end
                        end
                    end
                    StHdr: begin
                        if (hdr_done) begin
                            cur_state <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (is_write) begin
                            if (size_bad) begin
                                err[ErrBadSize] <= 1'b1;
                                cur_state       <= StIdle;
                            end else begin
                                remaining <= CntW'(total);
                                bram_addr <= '0;
                                cur_state <= StWrite;
                            end
                        end else begin
                            if (range_bad) begin
                                err[ErrBadRange] <= 1'b1;
                                cur_state        <= StIdle;
                            end else begin
                                remaining <= CntW'(field_b);
                                bram_addr <= ADDR_W'(field_a);
                                rd_wait   <= 1'b0;
                                cur_state <= StRdPre;
                            end
                        end
                    end
                    StWrite: begin
                        if (byte_valid) begin
                            bram_wdata <= byte_in;
                            bram_we    <= 1'b1;
                            remaining  <= remaining - CntW'(1);
                            if (remaining == CntW'(1)) begin
                                done      <= 1'b1;
                                cur_state <= StIdle;
                            end
                        end
                    end
                    StRdPre: begin
                        // First cycle lets the BRAM register the address.
                        if (!rd_wait) begin
                            rd_wait <= 1'b1;
                        end else begin
                            rd_wait   <= 1'b0;
                            tx_byte   <= bram_rdata;
                            cur_state <= StRead;
                        end
                    end
                    StRead: begin
                        if (byte_valid) begin
                            remaining <= remaining - CntW'(1);
                            if (remaining == CntW'(1)) begin
                                done      <= 1'b1;
                                cur_state <= StIdle;
                            end else begin
                                bram_addr <= bram_addr + ADDR_W'(1);
                                cur_state <= StRdPre;
                            end
                        end
                    end
                    default: begin
                        cur_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bram_xfer_ctrl.sv
// Scoreboard bench for spi_bram_xfer_ctrl: directed command streams push expected
// BRAM writes, read-back bytes and done pulses; a negedge monitor pops and compares.
module tb_spi_bram_xfer_ctrl;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 15;
    localparam int MEM_DEPTH = 19200;
    localparam int DIM_W     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_active = 1'b1;
    logic              byte_valid = 1'b0;
    logic [DATA_W-1:0] byte_in = '0;
    logic [DATA_W-1:0] tx_byte;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic [2:0]        state;
    logic              busy;
    logic              done;
    logic [2:0]        err;

    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [ADDR_W-1:0] exp_waddr [$];
    logic [DATA_W-1:0] exp_wdata [$];
    logic [DATA_W-1:0] exp_tx [$];
    int                exp_done = 0;
    logic [2:0]        prev_state = 3'd0;

    always #5 clk = ~clk;

    spi_bram_xfer_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .DIM_W     (DIM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .tx_byte      (tx_byte),
        .bram_addr    (bram_addr),
        .bram_we      (bram_we),
        .bram_wdata   (bram_wdata),
        .bram_rdata   (bram_rdata),
        .state        (state),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // BRAM model with one-cycle read latency; pre_* is a bench-only preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bram_we) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write pulse, done pulse and READ-entry tx_byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                if (exp_waddr.size() == 0) begin
                    check("unexpected_we", 32'(bram_addr), 32'hFFFF_FFFF);
                end else begin
                    check("we_addr", 32'(bram_addr), 32'(exp_waddr.pop_front()));
                    check("we_data", 32'(bram_wdata), 32'(exp_wdata.pop_front()));
                end
            end
            if (done) begin
                check("done_expected", 32'(exp_done > 0), 32'd1);
                if (exp_done > 0) exp_done--;
            end
            if (state == 3'd5 && prev_state != 3'd5) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_read", 32'(tx_byte), 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
                end
            end
        end
        prev_state = state;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50; i++) begin
            if (state == 3'd0) break;
            @(negedge clk);
        end
        check(name, 32'(state), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_tx"}, 32'(tx_byte), 32'd0);
        check({tag, "_addr"}, 32'(bram_addr), 32'd0);
        check({tag, "_we"}, 32'(bram_we), 32'd0);
        check({tag, "_wdata"}, 32'(bram_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 2x3 image: addresses 0..5, data 0x10..0x15.
        for (int i = 0; i < 6; i++) begin
            exp_waddr.push_back(ADDR_W'(i));
            exp_wdata.push_back(8'h10 + 8'(i));
        end
        exp_done++;
        send_cmd(8'h01, 16'h0002, 16'h0003);
        check("wr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        wait_idle("wr_idle");
        check("wr_err", 32'(err), 32'd0);

        // Read-back window BRAM[100..103].
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = ADDR_W'(100 + i);
            pre_data = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        pre_we = 1'b0;
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'hA0 + 8'(i));
        exp_done++;
        send_cmd(8'h02, 16'h0064, 16'h0004);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        wait_idle("rd_idle");
        check("rd_err", 32'(err), 32'd0);

        // Oversize write: 160 x 121 = 19360.
        send_cmd(8'h01, 16'h00A0, 16'h0079);
        repeat (3) @(negedge clk);
        wait_idle("ovs_idle");
        check("ovs_err", 32'(err), 32'd2);
        send_byte(8'h03);
        check("ovs_status", 32'(tx_byte), 32'h02);
        check("ovs_err_clr", 32'(err), 32'd0);

        // Bad opcode, then read window 19200 + 1.
        send_byte(8'h07);
        check("badcmd_err", 32'(err), 32'd1);
        send_cmd(8'h02, 16'h4B00, 16'h0001);
        repeat (3) @(negedge clk);
        wait_idle("rng_idle");
        check("rng_err", 32'(err), 32'd5);
        send_byte(8'h03);
        check("rng_status", 32'(tx_byte), 32'h05);
        check("rng_err_clr", 32'(err), 32'd0);

        // Abort after 3 of 6 write bytes.
        for (int i = 0; i < 3; i++) begin
            exp_waddr.push_back(ADDR_W'(i));
            exp_wdata.push_back(8'h30 + 8'(i));
        end
        send_cmd(8'h01, 16'h0002, 16'h0003);
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(state), 32'd0);
        check("abort_we", 32'(bram_we), 32'd0);
        frame_active = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_err", 32'(err), 32'd0);
        check("abort_writes_left", 32'(exp_waddr.size()), 32'd0);

        // Reset while in READ, then a normal 1x2 write.
        exp_tx.push_back(8'hA0);
        exp_tx.push_back(8'hA1);
        send_cmd(8'h02, 16'h0064, 16'h0004);
        send_byte(8'h00);
        check("mid_rd_state", 32'(state), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst1");
        rst = 1'b0;
        @(negedge clk);
        exp_waddr.push_back(ADDR_W'(0));
        exp_wdata.push_back(8'h55);
        exp_waddr.push_back(ADDR_W'(1));
        exp_wdata.push_back(8'h66);
        exp_done++;
        send_cmd(8'h01, 16'h0001, 16'h0002);
        send_byte(8'h55);
        send_byte(8'h66);
        wait_idle("wr2_idle");

        repeat (5) @(negedge clk);
        check("wq_empty", 32'(exp_waddr.size()), 32'd0);
        check("txq_empty", 32'(exp_tx.size()), 32'd0);
        check("done_left", 32'(exp_done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
